nbit_pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined successor to the combinational n-bit carry-lookahead adder.
- Splits a BIT_NUMBER-wide add/subtract into STAGES slices. Each slice is a CLA block; a registered carry passes between slices.
- Valid/ready handshakes on input and output, per-stage bubble collapsing, and signed-overflow and carry flags.
- Sits in the datapath between operand producers and the result consumer. Sustains one operation per clock.

---
 rtl/nbit_pipelined_cla_adder.sv | 116 +++++++++++
 tb/tb_nbit_pipelined_cla_adder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nbit_pipelined_cla_adder.sv
// Pipelined n-bit carry-lookahead add/subtract with valid/ready flow control.
// Each stage resolves one SLICE-wide slice; operands and partial sums ride along in the stage registers.
module nbit_pipelined_cla_adder #(
    parameter int BIT_NUMBER = 64,
    parameter int STAGES     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIT_NUMBER-1:0] X,
    input  logic [BIT_NUMBER-1:0] Y,
    input  logic                  initCin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIT_NUMBER-1:0] S,
    output logic                  Cout,
    output logic                  overflow
);

    localparam int SLICE = BIT_NUMBER / STAGES;
    localparam int LAST  = STAGES - 1;

    typedef struct packed {
        logic [BIT_NUMBER-1:0] x;
        logic [BIT_NUMBER-1:0] y;
        logic [BIT_NUMBER-1:0] s;
        logic                  c;
        logic                  ov;
    } stage_t;

    stage_t            src  [STAGES];
    stage_t            st_d [STAGES];
    stage_t            st_q [STAGES];
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] ld;
    logic [STAGES:0]   rdy;

    always_comb begin
        logic [SLICE:0]   cc;
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        int unsigned      j;

        cc    = '0;
        g     = '0;
        p     = '0;
        j     = 0;
        rdy   = '0;
        src_v = '0;
        v_d   = '0;
        ld    = '0;

        rdy[STAGES] = out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            j          = LAST - i;
            rdy[j]     = !v_q[j] | rdy[j+1];
        end

        // Stage 0 sources straight from the ports with operand prep applied.
        src[0].x  = X;
        src[0].y  = sub ? ~Y : Y;
        src[0].s  = '0;
        src[0].c  = sub | initCin;
        src[0].ov = 1'b0;
        src_v[0]  = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src[k]   = st_q[k-1];
            src_v[k] = v_q[k-1];
        end

        for (int unsigned k = 0; k < STAGES; k++) begin
            st_d[k] = src[k];
            cc      = '0;
            cc[0]   = src[k].c;
            g       = src[k].x[k*SLICE +: SLICE] & src[k].y[k*SLICE +: SLICE];
            p       = src[k].x[k*SLICE +: SLICE] ^ src[k].y[k*SLICE +: SLICE];
            for (int unsigned i = 0; i < SLICE; i++) begin
                cc[i+1] = g[i] | (p[i] & cc[i]);
            end
            st_d[k].s[k*SLICE +: SLICE] = p ^ cc[SLICE-1:0];
            st_d[k].c                   = cc[SLICE];
            if (k == LAST) begin
                st_d[k].ov = cc[SLICE] ^ cc[SLICE-1];
            end
            v_d[k] = rdy[k] ? src_v[k] : v_q[k];
            ld[k]  = rdy[k] & src_v[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    st_q[k] <= st_d[k];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[LAST];
    assign S         = st_q[LAST].s;
    assign Cout      = st_q[LAST].c;
    assign overflow  = st_q[LAST].ov;

endmodule

// File: tb/tb_nbit_pipelined_cla_adder.sv
// Directed self-checking bench for nbit_pipelined_cla_adder (64/4 main instance plus 8/1, 8/8, 32/2 sweeps).
module tb_nbit_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, initCin, sub, out_valid, out_ready, Cout, overflow;
    logic [63:0] X, Y, S;

    logic        sw_valid, sw_cin, sw_sub, sw_ordy;
    logic [31:0] sw_x, sw_y;
    logic        a_ir, a_ov, a_c, a_of;
    logic [7:0]  a_s;
    logic        b_ir, b_ov, b_c, b_of;
    logic [7:0]  b_s;
    logic        c_ir, c_ov, c_c, c_of;
    logic [31:0] c_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nbit_pipelined_cla_adder #(.BIT_NUMBER(64), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y),
        .initCin(initCin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout), .overflow(overflow));

    nbit_pipelined_cla_adder #(.BIT_NUMBER(8), .STAGES(1)) dut_8_1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(a_ir), .X(sw_x[7:0]), .Y(sw_y[7:0]),
        .initCin(sw_cin), .sub(sw_sub), .out_valid(a_ov), .out_ready(sw_ordy),
        .S(a_s), .Cout(a_c), .overflow(a_of));

    nbit_pipelined_cla_adder #(.BIT_NUMBER(8), .STAGES(8)) dut_8_8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(b_ir), .X(sw_x[7:0]), .Y(sw_y[7:0]),
        .initCin(sw_cin), .sub(sw_sub), .out_valid(b_ov), .out_ready(sw_ordy),
        .S(b_s), .Cout(b_c), .overflow(b_of));

    nbit_pipelined_cla_adder #(.BIT_NUMBER(32), .STAGES(2)) dut_32_2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(c_ir), .X(sw_x), .Y(sw_y),
        .initCin(sw_cin), .sub(sw_sub), .out_valid(c_ov), .out_ready(sw_ordy),
        .S(c_s), .Cout(c_c), .overflow(c_of));

    // Reference: plain wide addition on the masked operands, flags from sign bits.
    function automatic logic [65:0] ref_n(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic cin, input logic sb);
        logic [64:0] mask, full;
        logic [63:0] xm, ym, s;
        logic        c0, co, ov;
        mask = (65'd1 << w) - 65'd1;
        xm   = x & mask[63:0];
        ym   = (sb ? ~y : y) & mask[63:0];
        c0   = sb ? 1'b1 : cin;
        full = {1'b0, xm} + {1'b0, ym} + {64'd0, c0};
        s    = full[63:0] & mask[63:0];
        co   = full[w];
        ov   = (xm[w-1] == ym[w-1]) && (s[w-1] != xm[w-1]);
        return {ov, co, s};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; X = '0; Y = '0; initCin = 1'b0; sub = 1'b0;
        sw_valid = 1'b0; sw_cin = 1'b0; sw_sub = 1'b0; sw_ordy = 1'b1; sw_x = '0; sw_y = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, overflow, Cout, S} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b of=%b c=%b S=%h, want all zero", out_valid, overflow, Cout, S);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_flags;
        logic [63:0] vx [6];
        logic [63:0] vy [6];
        logic        vc [6];
        logic        vs [6];
        logic [65:0] ve [6];
        vx[0] = 64'hFFFF_FFFF_FFFF_FFFF; vy[0] = 64'd1; vc[0] = 0; vs[0] = 0; ve[0] = {1'b0, 1'b1, 64'h0};
        vx[1] = 64'h7FFF_FFFF_FFFF_FFFF; vy[1] = 64'd1; vc[1] = 0; vs[1] = 0; ve[1] = {1'b1, 1'b0, 64'h8000_0000_0000_0000};
        vx[2] = 64'd0;                   vy[2] = 64'd1; vc[2] = 0; vs[2] = 1; ve[2] = {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vx[3] = 64'd5;                   vy[3] = 64'd3; vc[3] = 1; vs[3] = 1; ve[3] = {1'b0, 1'b1, 64'd2};
        vx[4] = 64'd5;                   vy[4] = 64'd3; vc[4] = 1; vs[4] = 0; ve[4] = {1'b0, 1'b0, 64'd9};
        vx[5] = 64'h8000_0000_0000_0000; vy[5] = 64'd1; vc[5] = 0; vs[5] = 1; ve[5] = {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            X = vx[i]; Y = vy[i]; initCin = vc[i]; sub = vs[i]; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (2) @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flags_latency_early[%0d]: out_valid=%b want 0", i, out_valid);
            end
            @(negedge clk);
            n_checks++;
            if ({out_valid, overflow, Cout, S} !== {1'b1, ve[i]}) begin
                n_fail++;
                $display("FAIL flags_result[%0d]: got v=%b of=%b c=%b S=%h, want v=1 of=%b c=%b S=%h",
                         i, out_valid, overflow, Cout, S, ve[i][65], ve[i][64], ve[i][63:0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stream;
        logic [65:0] q[$];
        logic [65:0] e;
        int          got = 0;
        int          sent = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 110; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== ((cyc >= 4 && cyc < 104) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL stream_valid cyc=%0d: out_valid=%b", cyc, out_valid);
            end
            if (out_valid === 1'b1) begin
                e = (q.size() > 0) ? q.pop_front() : 66'h3_FFFF_FFFF_FFFF_FFFF;
                n_checks++;
                if ({overflow, Cout, S} !== e) begin
                    n_fail++;
                    $display("FAIL stream_result[%0d]: got of=%b c=%b S=%h, want of=%b c=%b S=%h",
                             got, overflow, Cout, S, e[65], e[64], e[63:0]);
                end
                got++;
            end
            if (sent < 100) begin
                X = {$urandom, $urandom}; Y = {$urandom, $urandom};
                initCin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
                q.push_back(ref_n(64, X, Y, initCin, sub));
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        n_checks++;
        if (got !== 100) begin
            n_fail++;
            $display("FAIL stream_count: got %0d results want 100", got);
        end
    endtask

    task automatic test_backpressure;
        logic [65:0] ex [6];
        int          idx = 0;
        int          got = 0;
        logic        rdy_seen = 1'b0;
        for (int i = 0; i < 6; i++) ex[i] = ref_n(64, 64'h0123_4567_89AB_CDEF * (i + 1), 64'(i), 1'b0, 1'b0);
        out_ready = 1'b0; in_valid = 1'b0; initCin = 1'b0; sub = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (in_valid && rdy_seen) idx++;
            if (cyc >= 5 && cyc < 10) begin
                n_checks++;
                if ({out_valid, overflow, Cout, S} !== {1'b1, ex[0]}) begin
                    n_fail++;
                    $display("FAIL bp_hold cyc=%0d: got v=%b S=%h want v=1 S=%h", cyc, out_valid, S, ex[0][63:0]);
                end
            end
            if (cyc == 10) begin
                n_checks++;
                if (idx !== 4 || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_buffered: accepted=%0d in_ready=%b, want 4 and 0", idx, in_ready);
                end
            end
            out_ready = (cyc >= 10);
            if (out_valid && out_ready) begin
                n_checks++;
                if (got > 5 || {overflow, Cout, S} !== ex[got]) begin
                    n_fail++;
                    $display("FAIL bp_drain[%0d]: got S=%h c=%b of=%b", got, S, Cout, overflow);
                end
                got++;
            end
            if (idx < 6) begin
                X = 64'h0123_4567_89AB_CDEF * (idx + 1); Y = 64'(idx); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1 rdy_seen = in_ready;
        end
        n_checks++;
        if (got !== 6 || idx !== 6) begin
            n_fail++;
            $display("FAIL bp_count: drained %0d accepted %0d, want 6 and 6", got, idx);
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b1; sub = 1'b0; initCin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            X = 64'd100 + 64'(i); Y = 64'd1; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || S !== 64'd0) begin
            n_fail++;
            $display("FAIL midreset_clear: out_valid=%b S=%h want 0 and 0", out_valid, S);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        X = 64'd5; Y = 64'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_stale[%0d]: out_valid=%b S=%h want 0", i, out_valid, S);
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || S !== 64'd8) begin
            n_fail++;
            $display("FAIL midreset_first: out_valid=%b S=%h want 1 and 8", out_valid, S);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_after: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_sweep;
        logic [65:0] qa[$];
        logic [65:0] qb[$];
        logic [65:0] qc[$];
        logic [65:0] e;
        int          n = 60;
        sw_ordy = 1'b1;
        for (int cyc = 0; cyc < n + 12; cyc++) begin
            @(negedge clk);
            n_checks++;
            if ({a_ov, b_ov, c_ov} !== {(cyc >= 1 && cyc < n + 1), (cyc >= 8 && cyc < n + 8), (cyc >= 2 && cyc < n + 2)}) begin
                n_fail++;
                $display("FAIL sweep_valid cyc=%0d: 8/1=%b 8/8=%b 32/2=%b", cyc, a_ov, b_ov, c_ov);
            end
            if (a_ov === 1'b1) begin
                e = (qa.size() > 0) ? qa.pop_front() : '1;
                n_checks++;
                if ({a_of, a_c, 56'd0, a_s} !== e) begin
                    n_fail++;
                    $display("FAIL sweep_8_1 cyc=%0d: got S=%h c=%b of=%b want S=%h c=%b of=%b", cyc, a_s, a_c, a_of, e[7:0], e[64], e[65]);
                end
            end
            if (b_ov === 1'b1) begin
                e = (qb.size() > 0) ? qb.pop_front() : '1;
                n_checks++;
                if ({b_of, b_c, 56'd0, b_s} !== e) begin
                    n_fail++;
                    $display("FAIL sweep_8_8 cyc=%0d: got S=%h c=%b of=%b want S=%h c=%b of=%b", cyc, b_s, b_c, b_of, e[7:0], e[64], e[65]);
                end
            end
            if (c_ov === 1'b1) begin
                e = (qc.size() > 0) ? qc.pop_front() : '1;
                n_checks++;
                if ({c_of, c_c, 32'd0, c_s} !== e) begin
                    n_fail++;
                    $display("FAIL sweep_32_2 cyc=%0d: got S=%h c=%b of=%b want S=%h c=%b of=%b", cyc, c_s, c_c, c_of, e[31:0], e[64], e[65]);
                end
            end
            if (cyc < n) begin
                case (cyc)
                    0:       begin sw_x = 32'hFFFF_FFFF; sw_y = 32'd1; sw_cin = 1'b0; sw_sub = 1'b0; end
                    1:       begin sw_x = 32'h7FFF_FF7F; sw_y = 32'd1; sw_cin = 1'b0; sw_sub = 1'b0; end
                    2:       begin sw_x = 32'h8000_0080; sw_y = 32'd1; sw_cin = 1'b1; sw_sub = 1'b1; end
                    3:       begin sw_x = 32'd0;         sw_y = 32'd0; sw_cin = 1'b1; sw_sub = 1'b1; end
                    default: begin sw_x = $urandom; sw_y = $urandom; sw_cin = 1'($urandom); sw_sub = 1'($urandom); end
                endcase
                sw_valid = 1'b1;
                qa.push_back(ref_n(8,  {32'd0, sw_x}, {32'd0, sw_y}, sw_cin, sw_sub));
                qb.push_back(ref_n(8,  {32'd0, sw_x}, {32'd0, sw_y}, sw_cin, sw_sub));
                qc.push_back(ref_n(32, {32'd0, sw_x}, {32'd0, sw_y}, sw_cin, sw_sub));
            end else begin
                sw_valid = 1'b0;
            end
        end
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) begin
            n_fail++;
            $display("FAIL sweep_count: left over 8/1=%0d 8/8=%0d 32/2=%0d", qa.size(), qb.size(), qc.size());
        end
    endtask

    initial begin
        test_reset();
        test_flags();
        test_stream();
        test_backpressure();
        test_reset_midstream();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
